// File: rtl/scramble_sequencer_if.sv
// -----------------------------------------------------------------------------
// scramble_sequencer_if
// Bundles the player-side inputs and the cell-array drive outputs of the
// scramble sequencer.
//   master : the sequencer (consumes player inputs, drives the cell stream)
//   slave  : the environment (drives player inputs, observes the cell stream)
// Signals:
//   start            one-cycle re-scramble request
//   user_fire        debounced, edge-detected fire pulse
//   user_row_column  one-hot row/column select from the switch checker
//   user_nRow        0 = row, 1 = column
//   user_error       more than one switch set
//   fire             one-cycle toggle strobe to the cells
//   row_column       one-hot select (registered)
//   x_nRow           0 = row, 1 = column (registered)
//   scramble_active  high while scrambling
//   done             one-cycle pulse when the scramble completes
//   moves_done       scramble moves issued in the current scramble
// -----------------------------------------------------------------------------
interface scramble_sequencer_if;
    logic       start;
    logic       user_fire;
    logic [3:0] user_row_column;
    logic       user_nRow;
    logic       user_error;
    logic       fire;
    logic [3:0] row_column;
    logic       x_nRow;
    logic       scramble_active;
    logic       done;
    logic [7:0] moves_done;

    modport master (
        input  start, user_fire, user_row_column, user_nRow, user_error,
        output fire, row_column, x_nRow, scramble_active, done, moves_done
    );

    modport slave (
        output start, user_fire, user_row_column, user_nRow, user_error,
        input  fire, row_column, x_nRow, scramble_active, done, moves_done
    );
endinterface

// File: rtl/scramble_sequencer.sv
// -----------------------------------------------------------------------------
// scramble_sequencer
// Upstream stage of the 4x4 toggle grid. After reset, or on a start request
// while in play, it issues MOVES pseudo-random row/column toggles, one every
// TICK_DIV+1 cycles, then passes the player's debounced inputs through with
// one cycle of latency.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    scramble_sequencer_if.master (player inputs in, cell stream out)
//
// Parameters:
//   MOVES      scramble moves per scramble (0..255)
//   TICK_DIV   clk cycles between scramble moves (>= 2)
//   LFSR_SEED  LFSR reset value (0 is replaced by 16'h0001)
//
// Optional feature (macro SCRAMBLE_NOREPEAT_EN):
//   When defined, a decoded move equal to the previous scramble move is
//   rejected and retried on the next clk with the next LFSR value.
// -----------------------------------------------------------------------------
module scramble_sequencer #(
    parameter int unsigned MOVES     = 16,
    parameter int unsigned TICK_DIV  = 1000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    scramble_sequencer_if.master bus
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]        MOVES_MAX = 8'(MOVES);
    // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
    localparam logic [15:0]       SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]       LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        SCR_WAIT,
        SCR_FIRE,
        FINISH,
        PLAY
    } state_t;

    state_t            r_state,        w_state_nxt;
    logic [TICK_W-1:0] r_tick,         w_tick_nxt;
    logic [15:0]       r_lfsr,         w_lfsr_nxt;
    logic              r_fire,         w_fire_nxt;
    logic [3:0]        r_row_column,   w_row_column_nxt;
    logic              r_x_nrow,       w_x_nrow_nxt;
    logic              r_active,       w_active_nxt;
    logic              r_done,         w_done_nxt;
    logic [7:0]        r_moves_done,   w_moves_done_nxt;

    logic [3:0]        w_move_rc;
    logic              w_move_xn;
    logic              w_expire;
    logic              w_repeat;

`ifdef SCRAMBLE_NOREPEAT_EN
    logic [3:0]        r_prev_rc,      w_prev_rc_nxt;
    logic              r_prev_xn,      w_prev_xn_nxt;
`endif

    // Galois step; the LFSR free-runs in every state.
    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

    // Move decode: bits [1:0] pick the line, bit [2] picks row or column.
    assign w_move_rc = 4'b0001 << r_lfsr[1:0];
    assign w_move_xn = r_lfsr[2];
    assign w_expire  = (r_tick == TICK_LAST);

`ifdef SCRAMBLE_NOREPEAT_EN
    // The cleared previous-move register (0000) never equals a one-hot move,
    // so the first move of a scramble is always accepted.
    assign w_repeat = (w_move_rc == r_prev_rc) && (w_move_xn == r_prev_xn);
`else
    assign w_repeat = 1'b0;
`endif

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge, independent of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= SCR_WAIT;
            r_tick       <= '0;
            r_lfsr       <= SEED;
            r_fire       <= 1'b0;
            r_row_column <= 4'b0000;
            r_x_nrow     <= 1'b0;
            r_active     <= 1'b1;
            r_done       <= 1'b0;
            r_moves_done <= 8'd0;
`ifdef SCRAMBLE_NOREPEAT_EN
            r_prev_rc    <= 4'b0000;
            r_prev_xn    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_fire       <= w_fire_nxt;
            r_row_column <= w_row_column_nxt;
            r_x_nrow     <= w_x_nrow_nxt;
            r_active     <= w_active_nxt;
            r_done       <= w_done_nxt;
            r_moves_done <= w_moves_done_nxt;
`ifdef SCRAMBLE_NOREPEAT_EN
            r_prev_rc    <= w_prev_rc_nxt;
            r_prev_xn    <= w_prev_xn_nxt;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick;
        w_fire_nxt       = 1'b0;
        w_row_column_nxt = r_row_column;
        w_x_nrow_nxt     = r_x_nrow;
        w_active_nxt     = r_active;
        w_done_nxt       = 1'b0;
        w_moves_done_nxt = r_moves_done;
`ifdef SCRAMBLE_NOREPEAT_EN
        w_prev_rc_nxt    = r_prev_rc;
        w_prev_xn_nxt    = r_prev_xn;
`endif

        case (r_state)
            SCR_WAIT: begin
                if (!w_expire) begin
                    w_tick_nxt = r_tick + 1'b1;
                end else if (r_moves_done == MOVES_MAX) begin
                    // done is high while FINISH is the current state.
                    w_tick_nxt  = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = FINISH;
                end else if (!w_repeat) begin
                    // The move is latched one cycle ahead of fire so the
                    // select lines are settled before the strobe.
                    w_tick_nxt       = '0;
                    w_row_column_nxt = w_move_rc;
                    w_x_nrow_nxt     = w_move_xn;
`ifdef SCRAMBLE_NOREPEAT_EN
                    w_prev_rc_nxt    = w_move_rc;
                    w_prev_xn_nxt    = w_move_xn;
`endif
                    w_state_nxt      = SCR_FIRE;
                end
                // A rejected repeat leaves the tick parked at its last value,
                // so the next LFSR value is tried on the very next cycle.
            end

            SCR_FIRE: begin
                w_fire_nxt       = 1'b1;
                w_moves_done_nxt = r_moves_done + 8'd1;
                w_state_nxt      = SCR_WAIT;
            end

            FINISH: begin
                w_active_nxt     = 1'b0;
                w_row_column_nxt = 4'b0000;
                w_state_nxt      = PLAY;
            end

            PLAY: begin
                if (bus.start) begin
                    // start wins over a simultaneous user fire.
                    w_state_nxt      = SCR_WAIT;
                    w_active_nxt     = 1'b1;
                    w_moves_done_nxt = 8'd0;
                    w_tick_nxt       = '0;
                    w_row_column_nxt = 4'b0000;
                    w_x_nrow_nxt     = 1'b0;
`ifdef SCRAMBLE_NOREPEAT_EN
                    w_prev_rc_nxt    = 4'b0000;
                    w_prev_xn_nxt    = 1'b0;
`endif
                end else begin
                    w_fire_nxt       = bus.user_fire & ~bus.user_error;
                    w_row_column_nxt = bus.user_error ? 4'b0000 : bus.user_row_column;
                    w_x_nrow_nxt     = bus.user_nRow;
                end
            end

            default: begin
                w_state_nxt = SCR_WAIT;
            end
        endcase
    end

    assign bus.fire            = r_fire;
    assign bus.row_column      = r_row_column;
    assign bus.x_nRow          = r_x_nrow;
    assign bus.scramble_active = r_active;
    assign bus.done            = r_done;
    assign bus.moves_done      = r_moves_done;

endmodule

// File: doc/scramble_sequencer.md
Name: scramble_sequencer

Overview:
- Upstream stage of the 4x4 toggle grid. Produces the single fire / row_column / x_nRow stream that drives the cell array.
- After reset, or on a start request, it issues MOVES pseudo-random row or column toggles at a paced rate. It then hands control to the player's debounced inputs.
- Replaces the hard-wired scramble_state / free-running fire path in the top level.

Parameters:
- MOVES, 16: number of scramble moves per scramble; legal range 0..255.
- TICK_DIV, 1000000: clk cycles between scramble moves; minimum 2.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset. A value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to re-scramble; honoured only in PLAY
- user_fire  in  1  one-cycle fire pulse, already debounced and edge-detected
- user_row_column  in  4  one-hot row/column select from the switch checker
- user_nRow  in  1  0 = row, 1 = column
- user_error  in  1  switch checker reports more than one switch set
- fire  out  1  one-cycle toggle strobe to the cells
- row_column  out  4  one-hot select, registered
- x_nRow  out  1  0 = row, 1 = column, registered
- scramble_active  out  1  high while scrambling
- done  out  1  one-cycle pulse when the scramble completes
- moves_done  out  8  count of scramble moves issued in the current scramble

Behaviour:
- Reset values:
  - fire = 0, row_column = 4'b0000, x_nRow = 0, done = 0, moves_done = 0.
  - scramble_active = 1; state = SCR_WAIT; tick counter = 0; LFSR = LFSR_SEED.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances every clk in every state; never reaches 0.
- Move decode from LFSR bits [2:0]:
  - [1:0]: 00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000.
  - [2] -> x_nRow.
- States:
  - SCR_WAIT: tick counter increments each cycle. When it reaches TICK_DIV-1, clear it. Then:
    - if moves_done == MOVES, go to FINISH;
    - otherwise latch the decoded move into row_column/x_nRow and go to SCR_FIRE.
  - SCR_FIRE: fire = 1 for exactly this cycle; moves_done += 1; return to SCR_WAIT.
    - row_column/x_nRow are stable for at least one cycle before fire and during it.
  - FINISH: done = 1 for one cycle; scramble_active goes to 0 on the next edge; row_column = 0000; go to PLAY.
  - PLAY: registered pass-through, latency 1 cycle.
    - fire(t+1) = user_fire(t) & ~user_error(t).
    - row_column(t+1) = user_error ? 0000 : user_row_column.
    - x_nRow(t+1) = user_nRow.
    - On start: go to SCR_WAIT, set scramble_active = 1, clear moves_done and the tick counter; no fire that cycle.
- MOVES = 0: the first tick expiry goes directly to FINISH; no fire is issued.
- Boundary conditions:
  - start while scramble_active: ignored.
  - start and user_fire in the same PLAY cycle: start wins; the user fire is dropped.
  - user_fire while scrambling: discarded, not queued.
  - Reset asserted mid-scramble or mid-play: all outputs go to reset values immediately (asynchronous). A new scramble begins after release; the LFSR reloads the seed.
- moves_done saturates at MOVES and holds its value through PLAY until the next scramble starts.

Optional Feature:
- Macro SCRAMBLE_NOREPEAT_EN.
- Defined:
  - A decoded move identical to the previous scramble move (same row_column and x_nRow) is rejected.
  - The FSM stays in SCR_WAIT and retries on the next clk with the new LFSR value, without restarting the tick count. This prevents self-cancelling double toggles.
  - The previous-move register is cleared at scramble start.
- Undefined:
  - Every decoded move is issued as-is; the previous-move register is not built.

Test Plan:
- MOVES=4, TICK_DIV=8, release reset:
  - exactly 4 fire pulses, spaced 9 cycles apart (8-cycle wait plus the fire cycle);
  - each pulse has a one-hot row_column held through it;
  - moves_done = 1,2,3,4;
  - done pulses once; scramble_active then falls.
- MOVES=0: no fire pulse; done after 8 cycles; enters PLAY.
- PLAY, user_row_column=0100, user_nRow=1, user_fire pulse -> next cycle fire=1, row_column=0100, x_nRow=1.
- PLAY, user_error=1 with user_fire pulse -> fire stays 0; row_column=0000.
- Reset pulled low after the 2nd scramble fire -> outputs immediately reset values. After release, the first fire's move matches the post-reset sequence from seed 16'hACE1, and 4 fresh moves follow.
- PLAY, start and user_fire in the same cycle -> no fire that cycle; scramble_active=1; moves_done=0. With SCRAMBLE_NOREPEAT_EN defined, no two consecutive scramble moves are identical across 255 moves.
